// File: rtl/univ_shift_seq.sv
// Universal shift register with SW-bit serial lanes and a shamt-step burst sequencer.
// Optional feature: define UNIV_SHIFT_ABORT_EN to add the abort input for RUN bursts.
module univ_shift_seq #(
  parameter int DW = 8,
  parameter int SW = 1,
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          sync_rst,
  input  logic [2:0]    ctrl,
  input  logic [DW-1:0] data,
  input  logic [SW-1:0] data_l,
  input  logic [SW-1:0] data_h,
  input  logic          start,
  input  logic [CW-1:0] shamt,
`ifdef UNIV_SHIFT_ABORT_EN
  input  logic          abort,
`endif
  output logic [DW-1:0] q,
  output logic          busy,
  output logic          done
);

  typedef enum logic [2:0] {
    OP_HOLD = 3'b000,
    OP_SHR  = 3'b001,
    OP_SHL  = 3'b010,
    OP_LOAD = 3'b011,
    OP_ROTR = 3'b100,
    OP_ROTL = 3'b101,
    OP_ASHR = 3'b110,
    OP_RSVD = 3'b111
  } op_t;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t        state, state_next;
  op_t           op_q, op_next;
  logic [CW-1:0] cnt, cnt_next;
  logic [DW-1:0] q_next;

  function automatic logic is_shift(input op_t op);
    return (op == OP_SHR) || (op == OP_SHL) || (op == OP_ROTR) ||
           (op == OP_ROTL) || (op == OP_ASHR);
  endfunction

  function automatic logic [DW-1:0] apply_op(input op_t op, input logic [DW-1:0] cur,
                                             input logic [SW-1:0] in_l,
                                             input logic [SW-1:0] in_h,
                                             input logic [DW-1:0] ld);
    case (op)
      OP_SHR:  return {in_h, cur[DW-1:SW]};
      OP_SHL:  return {cur[DW-SW-1:0], in_l};
      OP_LOAD: return ld;
      OP_ROTR: return {cur[SW-1:0], cur[DW-1:SW]};
      OP_ROTL: return {cur[DW-SW-1:0], cur[DW-1:DW-SW]};
      OP_ASHR: return {{SW{cur[DW-1]}}, cur[DW-1:SW]};
      default: return cur;
    endcase
  endfunction

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_next = state;
    op_next    = op_q;
    cnt_next   = cnt;
    q_next     = q;
    case (state)
      S_IDLE: begin
        if (start && is_shift(op_t'(ctrl))) begin
          // Latch edge: the op and count are captured, the register itself does not move.
          op_next    = op_t'(ctrl);
          cnt_next   = shamt;
          state_next = (shamt != '0) ? S_RUN : S_DONE;
        end else begin
          q_next = apply_op(op_t'(ctrl), q, data_l, data_h, data);
        end
      end
      S_RUN: begin
`ifdef UNIV_SHIFT_ABORT_EN
        if (abort) begin
          state_next = S_IDLE;
          cnt_next   = '0;
        end else
`endif
        begin
          q_next   = apply_op(op_q, q, data_l, data_h, data);
          cnt_next = cnt - CW'(1);
          if (cnt == CW'(1)) state_next = S_DONE;
        end
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (sync_rst) begin
      state <= S_IDLE;
      op_q  <= OP_HOLD;
      cnt   <= '0;
      q     <= '0;
    end else begin
      state <= state_next;
      op_q  <= op_next;
      cnt   <= cnt_next;
      q     <= q_next;
    end
  end

  assign busy = (state == S_RUN);
  assign done = (state == S_DONE);

endmodule

// File: tb/tb_univ_shift_seq.sv
// Directed bench for univ_shift_seq: vector table for per-cycle ops and bursts,
// hand-written sequences for reset timing, reset mid-burst and (when enabled) abort.
module tb_univ_shift_seq;

  logic       clk = 1'b0;
  logic       sync_rst;
  logic [2:0] ctrl;
  logic [7:0] data;
  logic       data_l, data_h, start;
  logic [3:0] shamt;
  logic [7:0] q;
  logic       busy, done;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

`ifdef UNIV_SHIFT_ABORT_EN
  logic       abort;
  logic [2:0] ctrl2;
  logic [7:0] data2;
  logic [1:0] dl2, dh2;
  logic       start2, abort2, busy2, done2;
  logic [3:0] shamt2;
  logic [7:0] q2;

  univ_shift_seq #(.DW(8), .SW(2), .CW(4)) u_dut2 (
    .clk(clk), .sync_rst(sync_rst), .ctrl(ctrl2), .data(data2), .data_l(dl2),
    .data_h(dh2), .start(start2), .shamt(shamt2), .abort(abort2),
    .q(q2), .busy(busy2), .done(done2)
  );
`endif

  univ_shift_seq #(.DW(8), .SW(1), .CW(4)) u_dut (
    .clk(clk), .sync_rst(sync_rst), .ctrl(ctrl), .data(data), .data_l(data_l),
    .data_h(data_h), .start(start), .shamt(shamt),
`ifdef UNIV_SHIFT_ABORT_EN
    .abort(abort),
`endif
    .q(q), .busy(busy), .done(done)
  );

  typedef struct {
    logic [2:0] ctrl;
    logic [7:0] data;
    logic       dl;
    logic       dh;
    logic       start;
    logic [3:0] shamt;
    logic [7:0] eq;
    logic       eb;
    logic       ed;
  } vec_t;

  localparam int NV = 20;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [7:0] eq, input logic eb,
                           input logic ed);
    check({tag, " q"}, 32'(q), 32'(eq));
    check({tag, " busy"}, 32'(busy), 32'(eb));
    check({tag, " done"}, 32'(done), 32'(ed));
  endtask

  // Outputs are sampled and inputs changed 2 time units after each rising edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    // ctrl, data, dl, dh, start, shamt, exp q, busy, done
    vecs[0]  = '{3'b011, 8'hA5, 1'b0, 1'b0, 1'b0, 4'd0, 8'hA5, 1'b0, 1'b0};
    vecs[1]  = '{3'b101, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0, 8'h4B, 1'b0, 1'b0};
    vecs[2]  = '{3'b110, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0, 8'h25, 1'b0, 1'b0};
    vecs[3]  = '{3'b100, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0, 8'h92, 1'b0, 1'b0};
    vecs[4]  = '{3'b111, 8'hFF, 1'b1, 1'b1, 1'b0, 4'd0, 8'h92, 1'b0, 1'b0};
    // shl burst of 3 with ctrl/start/data toggling while running
    vecs[5]  = '{3'b011, 8'h81, 1'b0, 1'b0, 1'b0, 4'd0, 8'h81, 1'b0, 1'b0};
    vecs[6]  = '{3'b010, 8'h00, 1'b1, 1'b0, 1'b1, 4'd3, 8'h81, 1'b1, 1'b0};
    vecs[7]  = '{3'b011, 8'hFF, 1'b1, 1'b0, 1'b1, 4'd7, 8'h03, 1'b1, 1'b0};
    vecs[8]  = '{3'b001, 8'hFF, 1'b1, 1'b0, 1'b0, 4'd0, 8'h07, 1'b1, 1'b0};
    vecs[9]  = '{3'b000, 8'h00, 1'b1, 1'b0, 1'b0, 4'd0, 8'h0F, 1'b0, 1'b1};
    vecs[10] = '{3'b011, 8'h00, 1'b0, 1'b0, 1'b1, 4'd2, 8'h0F, 1'b0, 1'b0};
    vecs[11] = '{3'b000, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0, 8'h0F, 1'b0, 1'b0};
    // zero-length burst, then start with a non-shift op
    vecs[12] = '{3'b001, 8'h00, 1'b0, 1'b1, 1'b1, 4'd0, 8'h0F, 1'b0, 1'b1};
    vecs[13] = '{3'b000, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0, 8'h0F, 1'b0, 1'b0};
    vecs[14] = '{3'b011, 8'h3C, 1'b0, 1'b0, 1'b1, 4'd2, 8'h3C, 1'b0, 1'b0};
    vecs[15] = '{3'b000, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0, 8'h3C, 1'b0, 1'b0};
    // rotl burst of 2
    vecs[16] = '{3'b101, 8'h00, 1'b0, 1'b0, 1'b1, 4'd2, 8'h3C, 1'b1, 1'b0};
    vecs[17] = '{3'b000, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0, 8'h78, 1'b1, 1'b0};
    vecs[18] = '{3'b000, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0, 8'hF0, 1'b0, 1'b1};
    vecs[19] = '{3'b000, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0, 8'hF0, 1'b0, 1'b0};

    sync_rst = 1'b1; ctrl = 3'b000; data = 8'h00; data_l = 1'b0; data_h = 1'b0;
    start = 1'b0; shamt = 4'd0;
`ifdef UNIV_SHIFT_ABORT_EN
    abort = 1'b0; ctrl2 = 3'b000; data2 = 8'h00; dl2 = 2'b00; dh2 = 2'b00;
    start2 = 1'b0; abort2 = 1'b0; shamt2 = 4'd0;
`endif
    tick(); tick();
    check_out("reset", 8'h00, 1'b0, 1'b0);

    // Reset raised mid-cycle takes effect only at the next rising edge.
    sync_rst = 1'b0; ctrl = 3'b011; data = 8'h5A;
    tick();
    check_out("load 5A", 8'h5A, 1'b0, 1'b0);
    ctrl = 3'b000;
    sync_rst = 1'b1;
    #3;
    check("rst midcycle q", 32'(q), 32'h5A);
    tick();
    check_out("rst edge", 8'h00, 1'b0, 1'b0);
    sync_rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      ctrl = vecs[i].ctrl; data = vecs[i].data; data_l = vecs[i].dl;
      data_h = vecs[i].dh; start = vecs[i].start; shamt = vecs[i].shamt;
      tick();
      check_out($sformatf("v%0d", i), vecs[i].eq, vecs[i].eb, vecs[i].ed);
    end

    // shr burst of 5 on F0, reset lands on the second step edge.
    ctrl = 3'b001; start = 1'b1; shamt = 4'd5; data_h = 1'b0;
    tick();
    check_out("b5 latch", 8'hF0, 1'b1, 1'b0);
    ctrl = 3'b000; start = 1'b0;
    tick();
    check_out("b5 step1", 8'h78, 1'b1, 1'b0);
    sync_rst = 1'b1;
    tick();
    check_out("b5 rst", 8'h00, 1'b0, 1'b0);
    sync_rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_out($sformatf("b5 after%0d", i), 8'h00, 1'b0, 1'b0);
    end

`ifdef UNIV_SHIFT_ABORT_EN
    // SW=2: load C3, shl burst of 4 with data_l=01, abort at the second step edge.
    ctrl2 = 3'b011; data2 = 8'hC3;
    tick();
    check("ab load q", 32'(q2), 32'hC3);
    ctrl2 = 3'b010; start2 = 1'b1; shamt2 = 4'd4; dl2 = 2'b01;
    tick();
    check("ab latch q", 32'(q2), 32'hC3);
    check("ab latch busy", 32'(busy2), 32'h1);
    ctrl2 = 3'b000; start2 = 1'b0;
    tick();
    check("ab step1 q", 32'(q2), 32'h0D);
    check("ab step1 busy", 32'(busy2), 32'h1);
    abort2 = 1'b1;
    tick();
    check("ab abort q", 32'(q2), 32'h0D);
    check("ab abort busy", 32'(busy2), 32'h0);
    check("ab abort done", 32'(done2), 32'h0);
    abort2 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("ab after%0d q", i), 32'(q2), 32'h0D);
      check($sformatf("ab after%0d done", i), 32'(done2), 32'h0);
      check($sformatf("ab after%0d busy", i), 32'(busy2), 32'h0);
    end
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
